// File: rtl/comma_aligner_10b.sv
// -----------------------------------------------------------------------------
// comma_aligner_10b
//
// Serial-to-parallel front end for the 10b/8b decoder. Bits from the CDR are
// shifted into a 10-bit window. K28.5 commas found in that window set the
// symbol boundary. Each aligned symbol is emitted together with the running
// disparity that precedes it, and code/disparity violations are flagged.
// A SEARCH -> SYNC -> LOCKED state machine handles lock acquisition and loss.
//
// Parameters
//   LOCK_COMMAS : aligned commas, including the aligning one, needed to lock (>=1)
//   LOSS_ERRS   : error symbols since the last aligned comma that drop lock (>=1)
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset
//   serial_in  in   1   line bit; bit 'a' of a symbol ends up in data_out[9]
//   bit_en     in   1   serial_in is valid this cycle; all state holds when low
//   data_out   out  10  aligned symbol {abcdei,fghj}
//   data_valid out  1   one-cycle pulse: data_out/rd/is_comma/disp_err are new
//   rd         out  1   running disparity preceding data_out (0=RD-, 1=RD+)
//   is_comma   out  1   data_out is K28.5 (either disparity)
//   disp_err   out  1   data_out has a code or disparity violation
//   locked     out  1   aligner is in the LOCKED state
//   realign    out  1   one-cycle pulse: symbol boundary was (re)set
// -----------------------------------------------------------------------------
module comma_aligner_10b #(
  parameter int unsigned LOCK_COMMAS = 3,
  parameter int unsigned LOSS_ERRS   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       bit_en,
  output logic [9:0] data_out,
  output logic       data_valid,
  output logic       rd,
  output logic       is_comma,
  output logic       disp_err,
  output logic       locked,
  output logic       realign
);

  // Counter widths: comma_cnt counts up to LOCK_COMMAS, err_cnt up to LOSS_ERRS.
  localparam int unsigned CCW = (LOCK_COMMAS > 32'd1) ? $clog2(LOCK_COMMAS + 32'd1) : 1;
  localparam int unsigned ECW = (LOSS_ERRS > 32'd1) ? $clog2(LOSS_ERRS + 32'd1) : 1;

  // Thresholds expressed as "current count before increment", so the
  // comparison never needs a wider intermediate.
  localparam logic [CCW-1:0] LOCK_LAST = CCW'(LOCK_COMMAS - 32'd1);
  localparam logic [ECW-1:0] ERR_LAST  = ECW'(LOSS_ERRS - 32'd1);

  localparam logic [9:0] K285_RDN = 10'b0011111010;  // K28.5 sent from RD-
  localparam logic [9:0] K285_RDP = 10'b1100000101;  // K28.5 sent from RD+

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Number of ones in a 10-bit code group.
  function automatic logic [3:0] ones10(input logic [9:0] v);
    logic [3:0] acc;
    acc = 4'd0;
    for (int i = 0; i < 10; i++) begin
      acc = acc + {3'b000, v[i]};
    end
    return acc;
  endfunction

  // Disparity rule on a symbol: 6 ones leaves RD+, 4 ones leaves RD-,
  // a neutral symbol (and any illegal weight) keeps the incoming value.
  function automatic logic rd_after(input logic [3:0] n, input logic rd_in);
    logic r;
    case (n)
      4'd6:    r = 1'b1;
      4'd4:    r = 1'b0;
      default: r = rd_in;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------
  logic [9:0]     sr_q;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  state_e         state_q, state_d;
  logic           rd_run_q, rd_run_d;
  logic [CCW-1:0] comma_cnt_q, comma_cnt_d;
  logic [ECW-1:0] err_cnt_q, err_cnt_d;

  logic [9:0]     data_out_q;
  logic           data_valid_q;
  logic           rd_q;
  logic           is_comma_q;
  logic           disp_err_q;
  logic           locked_q;
  logic           realign_q;

  // ---------------------------------------------------------------------------
  // Window decode
  // ---------------------------------------------------------------------------
  logic [9:0] win_s;
  logic       is_rdn_s;
  logic       is_rdp_s;
  logic       comma_s;
  logic       comma_hit_s;
  logic       cnt_wrap_s;
  logic       realign_hit_s;
  logic       boundary_s;
  logic       emit_s;
  logic [3:0] ones_s;
  logic       rd_base_s;
  logic       sym_err_s;

  assign win_s       = {sr_q[8:0], serial_in};
  assign is_rdn_s    = (win_s == K285_RDN);
  assign is_rdp_s    = (win_s == K285_RDP);
  assign comma_s     = is_rdn_s | is_rdp_s;
  assign comma_hit_s = bit_en & comma_s;
  assign cnt_wrap_s  = (bit_cnt_q == 4'd9);
  assign ones_s      = ones10(win_s);

  // In SEARCH any comma sets the boundary; in SYNC only a comma that does not
  // already sit on the current boundary moves it. LOCKED never realigns.
  assign realign_hit_s = comma_hit_s &
                         ((state_q == ST_SEARCH) |
                          ((state_q == ST_SYNC) & ~cnt_wrap_s));

  assign boundary_s = bit_en & (cnt_wrap_s | realign_hit_s);

  // SEARCH keeps counting symbols but only an aligning comma is emitted there.
  assign emit_s = boundary_s & ((state_q != ST_SEARCH) | realign_hit_s);

  // An aligning comma defines the running disparity from its own polarity.
  assign rd_base_s = realign_hit_s ? is_rdp_s : rd_run_q;

  // Error check against the incoming disparity; the aligning comma is
  // correct by construction.
  always_comb begin
    sym_err_s = 1'b0;
    if (realign_hit_s) begin
      sym_err_s = 1'b0;
    end else if ((ones_s < 4'd4) || (ones_s > 4'd6)) begin
      sym_err_s = 1'b1;
    end else if ((ones_s == 4'd6) && rd_run_q) begin
      sym_err_s = 1'b1;
    end else if ((ones_s == 4'd4) && !rd_run_q) begin
      sym_err_s = 1'b1;
    end else begin
      sym_err_s = 1'b0;
    end
  end

  // Bit counter and running-disparity next state.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    rd_run_d  = rd_run_q;
    if (bit_en) begin
      if (boundary_s) begin
        bit_cnt_d = 4'd0;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
    if (emit_s) begin
      rd_run_d = rd_after(ones_s, rd_base_s);
    end else begin
      rd_run_d = rd_run_q;
    end
  end

  // Lock state machine; only symbol boundaries can move it.
  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      ST_SEARCH: begin
        if (realign_hit_s) begin
          comma_cnt_d = CCW'(1);
          err_cnt_d   = {ECW{1'b0}};
          if (LOCK_COMMAS <= 32'd1) begin
            state_d = ST_LOCKED;
          end else begin
            state_d = ST_SYNC;
          end
        end else begin
          state_d = ST_SEARCH;
        end
      end

      ST_SYNC: begin
        if (realign_hit_s) begin
          // Misaligned comma: new boundary, count starts over.
          comma_cnt_d = CCW'(1);
          err_cnt_d   = {ECW{1'b0}};
          state_d     = ST_SYNC;
        end else if (boundary_s) begin
          if (sym_err_s) begin
            state_d = ST_SEARCH;
          end else if (comma_s) begin
            comma_cnt_d = comma_cnt_q + CCW'(1);
            if (comma_cnt_q >= LOCK_LAST) begin
              state_d   = ST_LOCKED;
              err_cnt_d = {ECW{1'b0}};
            end else begin
              state_d = ST_SYNC;
            end
          end else begin
            state_d = ST_SYNC;
          end
        end else begin
          state_d = ST_SYNC;
        end
      end

      ST_LOCKED: begin
        if (boundary_s) begin
          if (sym_err_s) begin
            err_cnt_d = err_cnt_q + ECW'(1);
            if (err_cnt_q >= ERR_LAST) begin
              state_d = ST_SEARCH;
            end else begin
              state_d = ST_LOCKED;
            end
          end else if (comma_s) begin
            err_cnt_d = {ECW{1'b0}};
            state_d   = ST_LOCKED;
          end else begin
            state_d = ST_LOCKED;
          end
        end else begin
          state_d = ST_LOCKED;
        end
      end

      default: begin
        state_d     = ST_SEARCH;
        comma_cnt_d = {CCW{1'b0}};
        err_cnt_d   = {ECW{1'b0}};
      end
    endcase
  end

  // Shift register, counters, disparity and FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q        <= 10'd0;
      bit_cnt_q   <= 4'd0;
      state_q     <= ST_SEARCH;
      rd_run_q    <= 1'b0;
      comma_cnt_q <= {CCW{1'b0}};
      err_cnt_q   <= {ECW{1'b0}};
    end else begin
      if (bit_en) begin
        sr_q <= win_s;
      end
      bit_cnt_q   <= bit_cnt_d;
      state_q     <= state_d;
      rd_run_q    <= rd_run_d;
      comma_cnt_q <= comma_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Registered symbol outputs; data fields hold between emitted symbols.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q   <= 10'd0;
      data_valid_q <= 1'b0;
      rd_q         <= 1'b0;
      is_comma_q   <= 1'b0;
      disp_err_q   <= 1'b0;
      locked_q     <= 1'b0;
      realign_q    <= 1'b0;
    end else begin
      data_valid_q <= emit_s;
      realign_q    <= emit_s & realign_hit_s;
      locked_q     <= (state_d == ST_LOCKED);
      if (emit_s) begin
        data_out_q <= win_s;
        rd_q       <= rd_base_s;
        is_comma_q <= comma_s;
        disp_err_q <= sym_err_s;
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign rd         = rd_q;
  assign is_comma   = is_comma_q;
  assign disp_err   = disp_err_q;
  assign locked     = locked_q;
  assign realign    = realign_q;

endmodule
